// File: rtl/wb_bus.sv
// wb_bus: per-unit result FIFOs with round-robin writeback broadcast.
// Optional macro WB_BYPASS_EN: empty-FIFO results skip straight to output.
module wb_bus #(
  parameter int NUM_UNITS = 4,
  parameter int FIN_WIDTH = 2,
  parameter int UID_BITS  = 4,
  parameter int DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_UNITS-1:0]            fu_valid,
  input  logic [NUM_UNITS*UID_BITS-1:0]   fu_uid,
  input  logic [NUM_UNITS*16-1:0]         fu_val,
  output logic [NUM_UNITS-1:0]            fu_ready,
  output logic [FIN_WIDTH-1:0]            bcast_valid,
  output logic [FIN_WIDTH*UID_BITS-1:0]   bcast_uid,
  output logic [FIN_WIDTH*16-1:0]         bcast_val,
  output logic [$clog2(FIN_WIDTH+1)-1:0]  bcast_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int BW = $clog2(FIN_WIDTH + 1);
  localparam int DW = UID_BITS + 16;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [DW-1:0] ent_t;

  ent_t           mem    [NUM_UNITS][DEPTH];
  logic [PW-1:0]  rd_ptr [NUM_UNITS];
  logic [PW-1:0]  wr_ptr [NUM_UNITS];
  logic [CW-1:0]  cnt    [NUM_UNITS];
  ent_t           in_ent [NUM_UNITS];

  logic [RW-1:0]        rr_ptr;
  logic [RW-1:0]        rr_nxt;
  logic [RW-1:0]        u_idx;
  int                   j;
  logic [NUM_UNITS-1:0] acc;
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] byp;
  logic [NUM_UNITS-1:0] push;
  logic [NUM_UNITS-1:0] pop;

  logic [FIN_WIDTH-1:0] nx_valid;
  ent_t                 nx_ent [FIN_WIDTH];
  logic [BW-1:0]        nx_cnt;

  // Unpack inputs; ready looks only at the pre-pop count.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      in_ent[u] = {fu_uid[u*UID_BITS +: UID_BITS],
                   fu_val[u*16 +: 16]};
      fu_ready[u] = !rst && (cnt[u] != CW'(DEPTH));
      acc[u] = fu_valid[u] && fu_ready[u] && !flush;
    end
  end

  // Scan units from rr_ptr and pack grants into slots without gaps.
  always_comb begin
    grant    = '0;
    byp      = '0;
    nx_valid = '0;
    nx_cnt   = '0;
    rr_nxt   = rr_ptr;
    u_idx    = '0;
    j        = 0;
    for (int s = 0; s < FIN_WIDTH; s++) begin
      nx_ent[s] = '0;
    end
    for (int i = 0; i < NUM_UNITS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_UNITS) begin
        j = j - NUM_UNITS;
      end
      u_idx = RW'(j);
      if ((cnt[u_idx] != '0 || (BYP && acc[u_idx])) &&
          nx_cnt < BW'(FIN_WIDTH)) begin
        grant[u_idx] = 1'b1;
        byp[u_idx]   = (cnt[u_idx] == '0);
        for (int s = 0; s < FIN_WIDTH; s++) begin
          if (nx_cnt == BW'(s)) begin
            nx_valid[s] = 1'b1;
            nx_ent[s] = (cnt[u_idx] != '0) ?
                        mem[u_idx][rd_ptr[u_idx]] :
                        in_ent[u_idx];
          end
        end
        nx_cnt = nx_cnt + 1'b1;
        rr_nxt = (j == NUM_UNITS - 1) ? '0 : RW'(j + 1);
      end
    end
  end

  // Bypassed results never touch the FIFO.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      push[u] = acc[u] && !byp[u];
      pop[u]  = grant[u] && !byp[u];
    end
  end

  // FIFO pointers and occupancy; flush empties everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        rd_ptr[u] <= '0;
        wr_ptr[u] <= '0;
        cnt[u]    <= '0;
      end
    end else if (flush) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        rd_ptr[u] <= '0;
        wr_ptr[u] <= '0;
        cnt[u]    <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (push[u]) begin
          wr_ptr[u] <= wr_ptr[u] + 1'b1;
        end
        if (pop[u]) begin
          rd_ptr[u] <= rd_ptr[u] + 1'b1;
        end
        cnt[u] <= cnt[u] + CW'(push[u]) - CW'(pop[u]);
      end
    end
  end

  // FIFO storage needs no reset; occupancy guards reads.
  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (push[u]) begin
        mem[u][wr_ptr[u]] <= in_ent[u];
      end
    end
  end

  // Registered broadcast and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcast_valid <= '0;
      bcast_uid   <= '0;
      bcast_val   <= '0;
      bcast_count <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      bcast_valid <= '0;
      bcast_uid   <= '0;
      bcast_val   <= '0;
      bcast_count <= '0;
    end else begin
      bcast_valid <= nx_valid;
      bcast_count <= nx_cnt;
      rr_ptr      <= rr_nxt;
      for (int s = 0; s < FIN_WIDTH; s++) begin
        bcast_uid[s*UID_BITS +: UID_BITS] <= nx_ent[s][DW-1:16];
        bcast_val[s*16 +: 16] <= nx_ent[s][15:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_bus.sv
// tb_wb_bus: queue-based reference model plus directed scenarios.
// Literal checks pin the model for the default and bypass builds.
module tb_wb_bus;

  localparam int NU = 4;
  localparam int FW = 2;
  localparam int UB = 4;
  localparam int DP = 4;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  logic [NU-1:0]    fu_valid;
  logic [NU*UB-1:0] fu_uid;
  logic [NU*16-1:0] fu_val;
  logic [NU-1:0]    fu_ready;
  logic [FW-1:0]    bcast_valid;
  logic [FW*UB-1:0] bcast_uid;
  logic [FW*16-1:0] bcast_val;
  logic [1:0]       bcast_count;

  logic        d_valid [NU];
  logic [3:0]  d_uid   [NU];
  logic [15:0] d_val   [NU];

  for (genvar g = 0; g < NU; g++) begin : g_drv
    assign fu_valid[g]          = d_valid[g];
    assign fu_uid[g*UB +: UB]   = d_uid[g];
    assign fu_val[g*16 +: 16]   = d_val[g];
  end

  wb_bus #(
    .NUM_UNITS(NU),
    .FIN_WIDTH(FW),
    .UID_BITS(UB),
    .DEPTH(DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .fu_valid(fu_valid),
    .fu_uid(fu_uid),
    .fu_val(fu_val),
    .fu_ready(fu_ready),
    .bcast_valid(bcast_valid),
    .bcast_uid(bcast_uid),
    .bcast_val(bcast_val),
    .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  logic [19:0] q [NU][$];
  int          rr;
  bit          m_acc [NU];
  logic [FW-1:0]    e_valid;
  logic [FW*UB-1:0] e_uid;
  logic [FW*16-1:0] e_val;
  logic [1:0]       e_cnt;
  int n_chk = 0;
  int n_pass = 0;
  int seq [NU];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      q[u].delete();
      m_acc[u] = 1'b0;
    end
    rr = 0;
    e_valid = '0;
    e_uid = '0;
    e_val = '0;
    e_cnt = '0;
  endtask

  // One clock edge of the reference behaviour, from bench inputs only.
  task automatic model_step();
    bit used [NU];
    int n;
    int last;
    int u;
    logic [19:0] item;
    e_valid = '0;
    e_uid = '0;
    e_val = '0;
    e_cnt = '0;
    for (int k = 0; k < NU; k++) m_acc[k] = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (flush) begin
      for (int k = 0; k < NU; k++) q[k].delete();
      return;
    end
    for (int k = 0; k < NU; k++) begin
      m_acc[k] = d_valid[k] && (q[k].size() < DP);
      used[k] = 1'b0;
    end
    n = 0;
    last = 0;
    for (int i = 0; i < NU; i++) begin
      u = (rr + i) % NU;
      if (n < FW && (q[u].size() > 0 || (BYP && m_acc[u]))) begin
        if (q[u].size() > 0) begin
          item = q[u].pop_front();
        end else begin
          item = {d_uid[u], d_val[u]};
          used[u] = 1'b1;
        end
        e_valid[n] = 1'b1;
        e_uid[n*UB +: UB] = item[19:16];
        e_val[n*16 +: 16] = item[15:0];
        n++;
        last = u;
      end
    end
    for (int k = 0; k < NU; k++) begin
      if (m_acc[k] && !used[k]) q[k].push_back({d_uid[k], d_val[k]});
    end
    if (n > 0) rr = (last + 1) % NU;
    e_cnt = 2'(n);
  endtask

  task automatic compare_all();
    logic [NU-1:0] er;
    for (int u = 0; u < NU; u++) er[u] = !rst && (q[u].size() < DP);
    check("bcast_valid", 64'(bcast_valid), 64'(e_valid));
    check("bcast_uid", 64'(bcast_uid), 64'(e_uid));
    check("bcast_val", 64'(bcast_val), 64'(e_val));
    check("bcast_count", 64'(bcast_count), 64'(e_cnt));
    check("fu_ready", 64'(fu_ready), 64'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    for (int u = 0; u < NU; u++) begin
      d_valid[u] = 1'b0;
      d_uid[u] = '0;
      d_val[u] = '0;
    end
  endtask

  task automatic set_in(int u, logic [3:0] uid, logic [15:0] val);
    d_valid[u] = 1'b1;
    d_uid[u] = uid;
    d_val[u] = val;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    tick();
    check("reset_valid", 64'(bcast_valid), 64'h0);
    check("reset_ready", 64'(fu_ready), 64'h0);
    tick();
    rst = 1'b0;

    // single result from unit 2
    set_in(2, 4'd5, 16'h1234);
    tick();
`ifdef WB_BYPASS_EN
    check("byp_valid", 64'(bcast_valid), 64'h1);
    check("byp_uid", 64'(bcast_uid[3:0]), 64'h5);
`else
    check("single_early", 64'(bcast_valid), 64'h0);
`endif
    idle();
    tick();
`ifndef WB_BYPASS_EN
    check("single_valid", 64'(bcast_valid), 64'h1);
    check("single_uid", 64'(bcast_uid[3:0]), 64'h5);
    check("single_val", 64'(bcast_val[15:0]), 64'h1234);
    check("single_cnt", 64'(bcast_count), 64'h1);
`endif
    tick();
    check("single_gone", 64'(bcast_valid), 64'h0);

    // round-robin with two results per unit
    pulse_reset();
    for (int u = 0; u < NU; u++) set_in(u, 4'(u*4), 16'(u*256));
    tick();
    for (int u = 0; u < NU; u++) set_in(u, 4'(u*4+1), 16'(u*256+1));
    tick();
`ifndef WB_BYPASS_EN
    check("rr_g01a", 64'(bcast_uid), 64'h40);
`endif
    idle();
    tick();
`ifndef WB_BYPASS_EN
    check("rr_g23a", 64'(bcast_uid), 64'hC8);
`endif
    tick();
`ifndef WB_BYPASS_EN
    check("rr_g01b", 64'(bcast_uid), 64'h51);
`endif
    tick();
`ifndef WB_BYPASS_EN
    check("rr_g23b", 64'(bcast_uid), 64'hD9);
`endif
    repeat (2) tick();
    check("rr_empty", 64'(bcast_valid), 64'h0);

    // backpressure: sources hold items until accepted
    pulse_reset();
    for (int u = 0; u < NU; u++) seq[u] = 0;
    for (int c = 1; c <= 8; c++) begin
      for (int u = 0; u < NU; u++)
        set_in(u, 4'(u*4 + seq[u] % 4), 16'(u*256 + seq[u]));
      tick();
      for (int u = 0; u < NU; u++) if (m_acc[u]) seq[u]++;
`ifndef WB_BYPASS_EN
      if (c == 7) check("bp_full", 64'(fu_ready), 64'hC);
      if (c == 8) check("bp_freed", 64'(fu_ready), 64'h3);
`endif
    end

    // flush while unit 3 pushes uid 9
    idle();
    set_in(3, 4'd9, 16'hBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_valid", 64'(bcast_valid), 64'h0);
    check("flush_ready", 64'(fu_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("flush_quiet", 64'(bcast_valid), 64'h0);
    end

    // asynchronous reset mid-cycle with results in flight
    for (int u = 0; u < 3; u++) set_in(u, 4'(u), 16'(u + 16'h50));
    tick();
    for (int u = 0; u < 3; u++) set_in(u, 4'(u+4), 16'(u + 16'h60));
    tick();
    idle();
    #2 rst = 1'b1;
    #1 model_reset();
    check("arst_valid", 64'(bcast_valid), 64'h0);
    check("arst_count", 64'(bcast_count), 64'h0);
    check("arst_ready", 64'(fu_ready), 64'h0);
    compare_all();
    tick();
    rst = 1'b0;
    tick();
    check("arst_quiet", 64'(bcast_valid), 64'h0);
    check("arst_ready1", 64'(fu_ready), 64'hF);
    set_in(0, 4'd1, 16'h0A0A);
    set_in(3, 4'd2, 16'h0B0B);
    tick();
    idle();
`ifdef WB_BYPASS_EN
    check("arst_rr0", 64'(bcast_uid), 64'h21);
`endif
    tick();
`ifndef WB_BYPASS_EN
    check("arst_rr0", 64'(bcast_uid), 64'h21);
`endif
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
